// File: rtl/snake_pkg.sv
// Shared snake game types: steering heading, grid position and body-move FSM states.
// Board and buffer size defaults live here so the interface and the datapath agree on widths.
package snake_pkg;

  localparam int GRID_W_DEF  = 32;
  localparam int GRID_H_DEF  = 24;
  localparam int MAX_LEN_DEF = 16;

  localparam int XW = $clog2(GRID_W_DEF);
  localparam int YW = $clog2(GRID_H_DEF);
  localparam int LW = $clog2(MAX_LEN_DEF + 1);
  localparam int IW = $clog2(MAX_LEN_DEF);

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    UP       = 3'd1,
    DOWN     = 3'd2,
    LEFT     = 3'd3,
    RIGHT    = 3'd4
  } direction;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pos_t;

  typedef enum logic [2:0] {
    WAIT_TICK,
    MOVE,
    CHECK,
    DONE,
    DEAD
  } state_t;

endpackage

// File: rtl/snake_body_move_if.sv
// Game-tick and drawing-side signals of the snake body mover.
// master = steering/drawing side, slave = body mover; no backpressure, all levels/pulses.
interface snake_body_move_if;
  import snake_pkg::*;

  logic          clk_divided;
  direction      dir;
  logic          grow;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic [IW-1:0] rd_idx;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_valid;
  logic          step_done;
  logic          collision;

  modport master (
    output clk_divided, dir, grow, rd_idx,
    input  head_x, head_y, length, rd_x, rd_y, rd_valid, step_done, collision
  );

  modport slave (
    input  clk_divided, dir, grow, rd_idx,
    output head_x, head_y, length, rd_x, rd_y, rd_valid, step_done, collision
  );

endinterface

// File: rtl/snake_next_pos.sv
// One-cell step of a grid position in a heading, wrapping at the board edges.
// Combinational, zero latency; no backpressure. Unknown headings leave the position unchanged.
module snake_next_pos
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  pos_t     cur,
  input  direction dir,
  output pos_t     nxt
);

  always_comb begin
    nxt = cur;
    case (dir)
      UP:      nxt.y = (cur.y == '0) ? YW'(GRID_H - 1) : cur.y - YW'(1);
      DOWN:    nxt.y = (cur.y == YW'(GRID_H - 1)) ? '0 : cur.y + YW'(1);
      LEFT:    nxt.x = (cur.x == '0) ? XW'(GRID_W - 1) : cur.x - XW'(1);
      RIGHT:   nxt.x = (cur.x == XW'(GRID_W - 1)) ? '0 : cur.x + XW'(1);
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/snake_body_move.sv
// Snake body mover: on each clk_divided falling edge shift the body, step the head, then scan for self-hit.
// Head moves 2 cycles after tick detect, step_done length+1 cycles after; no backpressure, early ticks dropped.
module snake_body_move
  import snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 16,
  parameter int INIT_Y   = 12
) (
  input logic              clk,
  input logic              rst,
  snake_body_move_if.slave bus
);

  state_t        state, state_nxt;
  pos_t          seg [MAX_LEN];
  pos_t          head_nxt;
  logic [LW-1:0] length, len_after_move;
  logic [IW-1:0] k;
  logic          clk_div_prev, grow_pending, collision;
  logic          tick, grow_eff, match, last_k;

  assign tick           = clk_div_prev & ~bus.clk_divided;
  assign grow_eff       = grow_pending | bus.grow;
  assign len_after_move = (grow_eff && length < LW'(MAX_LEN)) ? length + LW'(1) : length;
  assign match          = (seg[0] == seg[k]);
  assign last_k         = (LW'(k) == length - LW'(1));

  snake_next_pos #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_pos (
    .cur (seg[0]),
    .dir (bus.dir),
    .nxt (head_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_TICK;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_TICK: if (tick) state_nxt = MOVE;
      MOVE:      state_nxt = (len_after_move == LW'(1)) ? DONE : CHECK;
      CHECK: begin
        if (match)       state_nxt = DEAD;
        else if (last_k) state_nxt = DONE;
      end
      DONE:      state_nxt = WAIT_TICK;
      DEAD:      state_nxt = DEAD;
      default:   state_nxt = WAIT_TICK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_div_prev <= 1'b0;
      length       <= LW'(INIT_LEN);
      collision    <= 1'b0;
      grow_pending <= 1'b0;
      k            <= '0;
      // Body starts straight below the head, as if it had been travelling UP.
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) seg[i] <= '{x: XW'(INIT_X), y: YW'(INIT_Y + i)};
        else              seg[i] <= '0;
      end
    end else begin
      clk_div_prev <= bus.clk_divided;
      case (state)
        MOVE: begin
          for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
          seg[0]       <= head_nxt;
          length       <= len_after_move;
          grow_pending <= 1'b0;
          k            <= IW'(1);
        end
        CHECK: begin
          if (match)        collision <= 1'b1;
          else if (!last_k) k <= k + IW'(1);
          if (bus.grow) grow_pending <= 1'b1;
        end
        DEAD: ;
        default: if (bus.grow) grow_pending <= 1'b1;
      endcase
    end
  end

  assign bus.head_x    = seg[0].x;
  assign bus.head_y    = seg[0].y;
  assign bus.length    = length;
  assign bus.rd_x      = seg[bus.rd_idx].x;
  assign bus.rd_y      = seg[bus.rd_idx].y;
  assign bus.rd_valid  = (LW'(bus.rd_idx) < length);
  assign bus.step_done = (state == DONE);
  assign bus.collision = collision;

endmodule

// File: tb/tb_snake_body_move.sv
// Bench for snake_body_move: scenario tasks plus randomized walks against a cell-list reference model.
module tb_snake_body_move;
  import snake_pkg::*;

  localparam int GW = 32, GH = 24, ML = 16, IL = 3, IX = 16, IY = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int   mx [ML];
  int   my [ML];
  int   mlen;
  bit   mpend, mdead;

  snake_body_move_if bus ();

  snake_body_move #(
    .GRID_W (GW), .GRID_H (GH), .MAX_LEN (ML),
    .INIT_LEN (IL), .INIT_X (IX), .INIT_Y (IY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < ML; i++) begin
      mx[i] = (i < IL) ? IX : 0;
      my[i] = (i < IL) ? IY + i : 0;
    end
    mlen = IL; mpend = 0; mdead = 0;
  endtask

  task automatic model_step(input direction d);
    int hx, hy;
    if (mdead) return;
    hx = mx[0]; hy = my[0];
    case (d)
      UP:      hy = (hy + GH - 1) % GH;
      DOWN:    hy = (hy + 1) % GH;
      LEFT:    hx = (hx + GW - 1) % GW;
      RIGHT:   hx = (hx + 1) % GW;
      default: ;
    endcase
    for (int i = ML - 1; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
    mx[0] = hx; my[0] = hy;
    if (mpend && mlen < ML) mlen++;
    mpend = 0;
    for (int i = 1; i < mlen; i++) if (mx[i] == hx && my[i] == hy) mdead = 1;
  endtask

  task automatic do_reset();
    bus.clk_divided = 1'b0; bus.grow = 1'b0; bus.dir = UP; bus.rd_idx = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic pulse_grow();
    @(negedge clk) bus.grow = 1'b1;
    @(negedge clk) bus.grow = 1'b0;
    if (!mdead) mpend = 1;
  endtask

  // dat = sample index (1 = just after the tick-detect edge) of the first step_done seen.
  task automatic tick(input direction d, output int dcnt, output int dat);
    @(negedge clk); bus.dir = d; bus.clk_divided = 1'b1;
    @(negedge clk); @(negedge clk); bus.clk_divided = 1'b0;
    dcnt = 0; dat = 0;
    for (int c = 1; c <= ML + 6; c++) begin
      @(negedge clk);
      if (bus.step_done === 1'b1) begin
        dcnt++;
        if (dat == 0) dat = c;
      end
    end
    model_step(d);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.head_x !== 5'd16 || bus.head_y !== 5'd12 || bus.length !== 5'd3)
      begin errors++; $display("FAIL reset_head: got (%0d,%0d) len %0d expected (16,12) len 3", bus.head_x, bus.head_y, bus.length); end
    checks++;
    if (bus.collision !== 1'b0 || bus.step_done !== 1'b0)
      begin errors++; $display("FAIL reset_flags: got coll %0b done %0b expected 0 0", bus.collision, bus.step_done); end
    bus.rd_idx = 4'd2; #1;
    checks++;
    if (bus.rd_x !== 5'd16 || bus.rd_y !== 5'd14 || bus.rd_valid !== 1'b1)
      begin errors++; $display("FAIL reset_seg2: got (%0d,%0d,v%0b) expected (16,14,v1)", bus.rd_x, bus.rd_y, bus.rd_valid); end
    bus.rd_idx = 4'd3; #1;
    checks++;
    if (bus.rd_valid !== 1'b0)
      begin errors++; $display("FAIL reset_seg3_valid: got %0b expected 0", bus.rd_valid); end
  endtask

  task automatic test_step_up();
    int dc, da;
    int ey [3] = '{11, 12, 13};
    tick(UP, dc, da);
    checks++;
    if (dc != 1 || da != 4)
      begin errors++; $display("FAIL step_up_done: got %0d pulses at %0d expected 1 at 4", dc, da); end
    for (int i = 0; i < 3; i++) begin
      bus.rd_idx = 4'(i); #1;
      checks++;
      if (bus.rd_x !== 5'd16 || bus.rd_y !== 5'(ey[i]))
        begin errors++; $display("FAIL step_up_seg%0d: got (%0d,%0d) expected (16,%0d)", i, bus.rd_x, bus.rd_y, ey[i]); end
    end
  endtask

  task automatic test_wrap();
    int dc, da;
    do_reset();
    for (int s = 0; s < 17; s++) begin
      tick(LEFT, dc, da);
      checks++;
      if (bus.head_x !== 5'(mx[0]) || dc != 1)
        begin errors++; $display("FAIL wrap_left_step%0d: got x %0d done %0d expected x %0d done 1", s, bus.head_x, dc, mx[0]); end
    end
    checks++;
    if (bus.head_x !== 5'd31)
      begin errors++; $display("FAIL wrap_x: got %0d expected 31", bus.head_x); end
    for (int s = 0; s < 13; s++) begin
      tick(UP, dc, da);
      checks++;
      if (bus.head_y !== 5'(my[0]) || dc != 1)
        begin errors++; $display("FAIL wrap_up_step%0d: got y %0d done %0d expected y %0d done 1", s, bus.head_y, dc, my[0]); end
    end
    checks++;
    if (bus.head_y !== 5'd23)
      begin errors++; $display("FAIL wrap_y: got %0d expected 23", bus.head_y); end
  endtask

  task automatic test_grow();
    int dc, da;
    do_reset();
    pulse_grow();
    tick(UP, dc, da);
    bus.rd_idx = 4'd3; #1;
    checks++;
    if (bus.length !== 5'd4 || bus.rd_x !== 5'd16 || bus.rd_y !== 5'd14 || bus.rd_valid !== 1'b1)
      begin errors++; $display("FAIL grow_first: got len %0d tail (%0d,%0d) expected len 4 tail (16,14)", bus.length, bus.rd_x, bus.rd_y); end
    for (int s = 0; s < 12; s++) begin
      pulse_grow();
      tick(UP, dc, da);
      checks++;
      if (bus.length !== 5'(mlen) || da != mlen + 1)
        begin errors++; $display("FAIL grow_len%0d: got len %0d done@%0d expected len %0d done@%0d", s, bus.length, da, mlen, mlen + 1); end
    end
    checks++;
    if (bus.length !== 5'd16)
      begin errors++; $display("FAIL grow_full: got %0d expected 16", bus.length); end
    pulse_grow();
    tick(UP, dc, da);
    checks++;
    if (bus.length !== 5'd16 || bus.collision !== 1'b0 || dc != 1 || da != 17)
      begin errors++; $display("FAIL grow_cap: got len %0d coll %0b done %0d@%0d expected 16 0 1@17", bus.length, bus.collision, dc, da); end
  endtask

  task automatic test_collision();
    int dc, da;
    do_reset();
    tick(UP, dc, da);
    pulse_grow(); tick(RIGHT, dc, da);
    pulse_grow(); tick(DOWN, dc, da);
    tick(LEFT, dc, da);
    checks++;
    if (bus.collision !== 1'b1 || dc != 0 || bus.head_x !== 5'd16 || bus.head_y !== 5'd12)
      begin errors++; $display("FAIL collide: got coll %0b done %0d head (%0d,%0d) expected 1 0 (16,12)", bus.collision, dc, bus.head_x, bus.head_y); end
    pulse_grow();
    tick(UP, dc, da);
    checks++;
    if (bus.head_x !== 5'd16 || bus.head_y !== 5'd12 || bus.length !== 5'd5 || dc != 0 || bus.collision !== 1'b1)
      begin errors++; $display("FAIL dead_hold: got (%0d,%0d) len %0d done %0d expected (16,12) len 5 done 0", bus.head_x, bus.head_y, bus.length, dc); end
  endtask

  task automatic test_async_reset();
    int dc, da;
    do_reset();
    @(negedge clk); bus.dir = UP; bus.clk_divided = 1'b1;
    @(negedge clk); @(negedge clk); bus.clk_divided = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if (bus.head_y !== 5'd11)
      begin errors++; $display("FAIL arst_midstep: got y %0d expected 11", bus.head_y); end
    rst = 1'b0; #1;
    bus.rd_idx = 4'd2; #1;
    checks++;
    if (bus.head_x !== 5'd16 || bus.head_y !== 5'd12 || bus.length !== 5'd3 || bus.step_done !== 1'b0 ||
        bus.collision !== 1'b0 || bus.rd_y !== 5'd14)
      begin errors++; $display("FAIL arst_values: got (%0d,%0d) len %0d done %0b coll %0b seg2y %0d expected (16,12) 3 0 0 14",
                               bus.head_x, bus.head_y, bus.length, bus.step_done, bus.collision, bus.rd_y); end
    @(negedge clk); rst = 1'b1;
    model_reset();
    tick(UP, dc, da);
    checks++;
    if (dc != 1 || da != 4 || bus.head_y !== 5'd11)
      begin errors++; $display("FAIL arst_resume: got done %0d@%0d y %0d expected 1@4 y 11", dc, da, bus.head_y); end
  endtask

  task automatic test_random();
    direction d, last;
    int dc, da, r;
    bit rev;
    for (int round = 0; round < 2; round++) begin
      do_reset();
      last = UP;
      for (int s = 0; s < 30; s++) begin
        if ($urandom_range(0, 2) == 0) pulse_grow();
        r = $urandom_range(0, 15);
        if (r == 0) d = direction'(3'd7);
        else begin
          d = direction'(3'($urandom_range(1, 4)));
          rev = (d == UP && last == DOWN) || (d == DOWN && last == UP) ||
                (d == LEFT && last == RIGHT) || (d == RIGHT && last == LEFT);
          if (rev) d = last;
          last = d;
        end
        tick(d, dc, da);
        checks++;
        if (mdead ? (dc != 0 || bus.collision !== 1'b1) : (dc != 1 || da != mlen + 1 || bus.collision !== 1'b0))
          begin errors++; $display("FAIL rand_step r%0d s%0d: got done %0d@%0d coll %0b expected dead=%0b len %0d", round, s, dc, da, bus.collision, mdead, mlen); end
        checks++;
        if (bus.length !== 5'(mlen))
          begin errors++; $display("FAIL rand_len r%0d s%0d: got %0d expected %0d", round, s, bus.length, mlen); end
        for (int i = 0; i < ML; i++) begin
          bus.rd_idx = 4'(i); #1;
          checks++;
          if (bus.rd_x !== 5'(mx[i]) || bus.rd_y !== 5'(my[i]) || bus.rd_valid !== (i < mlen))
            begin errors++; $display("FAIL rand_seg r%0d s%0d i%0d: got (%0d,%0d,v%0b) expected (%0d,%0d,v%0b)",
                                     round, s, i, bus.rd_x, bus.rd_y, bus.rd_valid, mx[i], my[i], (i < mlen)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_wrap();
    test_grow();
    test_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_body_move.md
Name: snake_body_move

Overview:
- Game-tick consumer of the `direction` value produced by the mouse steering stage.
- On each falling edge of `clk_divided`, advances the snake head one cell in `dir`, wrapping at board edges.
- Shifts the body segment buffer, optionally grows, then scans for self-collision.
- Exposes head position, length and an indexed segment read port to the drawing logic.

Parameters:
GRID_W, 32, board width in cells
GRID_H, 24, board height in cells
MAX_LEN, 16, segment buffer depth (maximum snake length)
INIT_LEN, 3, length after reset (1..MAX_LEN)
INIT_X, 16, head x after reset
INIT_Y, 12, head y after reset

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
clk_divided  in  1  game tick; falling edge = step
dir  in  direction  heading from the steering stage, sampled on the step
grow  in  1  one-cycle pulse: food eaten
head_x  out  XW=$clog2(GRID_W)  segment 0 x
head_y  out  YW=$clog2(GRID_H)  segment 0 y
length  out  LW=$clog2(MAX_LEN+1)  current length
rd_idx  in  $clog2(MAX_LEN)  segment read index (0 = head)
rd_x  out  XW  x of segment rd_idx (combinational)
rd_y  out  YW  y of segment rd_idx (combinational)
rd_valid  out  1  rd_idx < length
step_done  out  1  one-cycle pulse: step finished, no collision
collision  out  1  sticky: head hit body

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - seg[i] = (INIT_X, INIT_Y+i) for i < INIT_LEN; the body trails below a head facing UP. Other entries are 0.
  - length = INIT_LEN.
  - collision = 0, step_done = 0, grow_pending = 0.
  - clk_div_prev = 0, state = WAIT_TICK.
- Tick detection: `clk_div_prev` is registered each clk. A tick is `clk_div_prev==1 && clk_divided==0`, the same edge on which the steering stage rearms.
- FSM WAIT_TICK: on tick, go to MOVE; otherwise stay.
- FSM MOVE (one cycle), updated at its closing edge:
  - seg[i] <= seg[i-1] for i = 1..MAX_LEN-1.
  - seg[0] <= next position of seg[0] in `dir`.
  - If (grow_pending | grow) and length < MAX_LEN: length <= length+1, so the old tail is retained. At MAX_LEN, growth is silently dropped.
  - grow_pending <= 0.
  - Go to CHECK with scan index k = 1; if the new length is 1, go directly to DONE.
- FSM CHECK: compare seg[0] against seg[k], one index per cycle.
  - On a match: collision <= 1, go to DEAD.
  - If k == length-1 with no match: go to DONE.
  - Otherwise: k <= k+1.
- FSM DONE: step_done = 1 for this cycle only; return to WAIT_TICK.
- FSM DEAD: terminal. Ticks and grow are ignored, outputs hold, and only reset exits.
- Next-position rules (mod arithmetic, no out-of-range values ever stored):
  - UP: y-1, with y=0 going to GRID_H-1.
  - DOWN: y+1, with GRID_H-1 going to 0.
  - LEFT: x-1, with 0 going to GRID_W-1.
  - RIGHT: x+1, with GRID_W-1 going to 0.
  - Any other encoding: no move.
- Tail-chasing is legal: the check runs after the shift, so the cell just vacated by the tail does not count.
- grow pulse outside MOVE sets grow_pending (sticky until the next MOVE).
- Ticks arriving in MOVE/CHECK/DONE are dropped. System requirement: tick period > MAX_LEN+2 clk cycles.
- Step latency:
  - head_x/head_y change at the end of the cycle following the tick-detect cycle.
  - step_done fires length+1 cycles after the tick-detect cycle.
- Reverse motion is not filtered here (the steering stage only allows 90° turns).

Decomposition:
- snake_pkg already holds `direction`.
- Add to snake_pkg: GRID_W/GRID_H/MAX_LEN defaults, a `pos_t` packed struct {x, y}, and a state enum.
- Sub-module `snake_next_pos`: combinational wrap-around step of a `pos_t` by `direction`, parameterised by GRID_W/GRID_H.

Test Plan:
- Reset release -> head (16,12), length 3, rd_idx=2 gives (16,14), rd_idx=3 gives rd_valid=0, collision=0.
- dir=UP, one clk_divided falling edge -> segs (16,11),(16,12),(16,13); step_done single pulse 4 cycles after tick detect.
- Head forced to x=0 via LEFT steps, dir=LEFT tick -> head_x=31. Also check y=0 with UP -> head_y=23.
- grow pulse, then tick -> length 4, tail (16,14) retained. Repeat to 16, then grow+tick -> length stays 16, no collision.
- grow+RIGHT tick, grow+DOWN tick, LEFT tick -> head (16,13) matches seg4 -> collision=1, no step_done. Further ticks leave head unchanged.
- Assert rst=0 mid-CHECK (asynchronously, between clk edges) -> all outputs at reset values immediately. Release -> normal step on next tick.
